pulse_stretch: RTL and testbench
================================

PULSE_STRETCH -- requirements
Module: pulse_stretch

Interface
REQ-001 SHALL have parameter c_ON_LIMIT, default 2500000, output-high duration in clock cycles (100 ms at 25 MHz); legal range 1..4194303.
REQ-002 SHALL have parameter c_GAP_LIMIT, default 1250000, minimum output-low gap in cycles between stretched pulses; legal range 1..4194303.
REQ-003 SHALL have parameter c_PEND_MAX, default 15, saturation value of the pending-event counter; legal range 1..15.
REQ-004 i_clk  input  1  single clock; all logic rising-edge.
REQ-005 i_rst  input  1  reset, asynchronous, active-high.
REQ-006 i_event  input  1  event strobe; every cycle sampled high counts as one event.
REQ-007 o_pulse  output  1  stretched, registered output level.
REQ-008 o_busy  output  1  high whenever state is not IDLE.
REQ-009 o_pending  output  4  events queued but not yet replayed.
REQ-010 o_drop  output  1  single-cycle strobe: an event was discarded because the queue was saturated.

Function
REQ-011 SHALL implement FSM with states IDLE, ON, GAP; one 22-bit cycle counter shared by ON and GAP.
REQ-012 IDLE: o_pulse=0; i_event=1 -> ON next cycle, counter=0; pending not incremented.
REQ-013 ON: o_pulse=1 for exactly c_ON_LIMIT consecutive cycles, starting the cycle after the triggering event (latency 1); at counter==c_ON_LIMIT-1 -> GAP, counter=0.
REQ-014 GAP: o_pulse=0 for exactly c_GAP_LIMIT cycles; at counter==c_GAP_LIMIT-1: pending>0 -> ON with pending decremented, else -> IDLE.
REQ-015 i_event=1 in ON or GAP SHALL increment pending, saturating at c_PEND_MAX; event at saturation SHALL assert o_drop the following cycle and leave pending unchanged.
REQ-016 Event in the same cycle as the GAP-exit decrement SHALL leave pending unchanged (net +1 -1); no drop in that cycle even at saturation.
REQ-017 Counter SHALL never exceed the active limit; no wrap-around.
REQ-018 o_busy SHALL be high from the first ON cycle until the cycle IDLE is entered.
REQ-019 All outputs SHALL be registered; no combinational path from i_event to any output.

Reset
REQ-020 i_rst=1 SHALL immediately (asynchronously) force state=IDLE, counter=0, pending=0, o_pulse=0, o_busy=0, o_drop=0.
REQ-021 Reset mid-ON or mid-GAP SHALL discard all pending events; events sampled while i_rst=1 are ignored.
REQ-022 First event accepted is the first rising edge with i_rst=0 and i_event=1.

Structure
REQ-023 State encoding (IDLE/ON/GAP) and counter width constant (22) SHALL live in shared package pulse_stretch_pkg.
REQ-024 Single flat module; no sub-module.

Verification (c_ON_LIMIT=4, c_GAP_LIMIT=2, c_PEND_MAX=3 unless stated)
REQ-025 Single event at edge 10 -> o_pulse high edges 11-14, low 15-16, o_busy falls at edge 17, o_pending stays 0.
REQ-026 One event during ON -> o_pending=1; second pulse high edges 17-20 after exact 2-cycle gap; o_pending returns to 0 at edge 17.
REQ-027 Five consecutive events during ON -> o_pending saturates at 3, o_drop pulses exactly twice, exactly 4 pulses emitted in total, then IDLE.
REQ-028 Event on final GAP cycle with pending=1 -> pending stays 1, next pulse starts immediately, one further pulse follows.
REQ-029 i_rst asserted asynchronously mid-ON with pending=2 -> o_pulse, o_busy, o_pending 0 before next clock edge; no pulse after release without new event.
REQ-030 c_ON_LIMIT=1, c_GAP_LIMIT=1, back-to-back events every cycle -> alternating 1/0 output pattern, no counter overflow.

Source files
------------

// File: rtl/pulse_stretch_pkg.sv
// Shared types and constants for the pulse stretcher: FSM state encoding
// and the widths of the shared cycle counter and the pending-event counter.
package pulse_stretch_pkg;

    localparam int c_CNT_W  = 22;
    localparam int c_PEND_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/pulse_stretch.sv
// Stretches each input event into a fixed-length high pulse followed by a
// guaranteed low gap; events arriving while busy are queued and replayed.
module pulse_stretch
    import pulse_stretch_pkg::*;
#(
    parameter int unsigned c_ON_LIMIT  = 2500000,
    parameter int unsigned c_GAP_LIMIT = 1250000,
    parameter int unsigned c_PEND_MAX  = 15
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_event,
    output logic                o_pulse,
    output logic                o_busy,
    output logic [c_PEND_W-1:0] o_pending,
    output logic                o_drop
);

    localparam logic [c_CNT_W-1:0]  c_ON_LAST  = c_CNT_W'(c_ON_LIMIT - 1);
    localparam logic [c_CNT_W-1:0]  c_GAP_LAST = c_CNT_W'(c_GAP_LIMIT - 1);
    localparam logic [c_PEND_W-1:0] c_PEND_TOP = c_PEND_W'(c_PEND_MAX);

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_PEND_W-1:0] r_pend;
    logic                r_pulse;
    logic                r_busy;
    logic                r_drop;

    logic w_on_done;
    logic w_gap_done;
    logic w_pend_full;
    logic w_replay;

    assign w_on_done   = (r_cnt == c_ON_LAST);
    assign w_gap_done  = (r_cnt == c_GAP_LAST);
    assign w_pend_full = (r_pend == c_PEND_TOP);
    // An event landing on the last gap cycle is consumed directly by the replay.
    assign w_replay    = (r_pend != '0) || i_event;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // branch below reads the pre-edge values of r_cnt/r_pend consistently.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_pend  <= '0;
            r_pulse <= 1'b0;
            r_busy  <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_drop <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_event) begin
                        r_state <= ST_ON;
                        r_cnt   <= '0;
                        r_pulse <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end

                ST_ON: begin
                    if (w_on_done) begin
                        r_state <= ST_GAP;
                        r_cnt   <= '0;
                        r_pulse <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (i_event) begin
                        if (w_pend_full) r_drop <= 1'b1;
                        else             r_pend <= r_pend + 1'b1;
                    end
                end

                ST_GAP: begin
                    if (w_gap_done) begin
                        if (w_replay) begin
                            r_state <= ST_ON;
                            r_cnt   <= '0;
                            r_pulse <= 1'b1;
                            if (!i_event) r_pend <= r_pend - 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_cnt   <= '0;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (i_event) begin
                            if (w_pend_full) r_drop <= 1'b1;
                            else             r_pend <= r_pend + 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_pend  <= '0;
                    r_pulse <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_pulse   = r_pulse;
    assign o_busy    = r_busy;
    assign o_pending = r_pend;
    assign o_drop    = r_drop;

endmodule

// File: tb/tb_pulse_stretch.sv
// Self-checking bench: two pulse_stretch instances (4/2/3 and 1/1/3) against a
// timeline-based reference model, directed scenarios plus random traffic.
module tb_pulse_stretch;

    localparam int A_ON = 4, A_GAP = 2, A_MAX = 3;
    localparam int B_ON = 1, B_GAP = 1, B_MAX = 3;

    logic       clk;
    logic       rst;
    logic       ev_a, ev_b;
    logic       pulse_a, busy_a, drop_a;
    logic       pulse_b, busy_b, drop_b;
    logic [3:0] pend_a, pend_b;

    int n_checks = 0;
    int n_fail   = 0;
    int t_edge   = 0;

    // Reference model: a pulse is described by the edge it started on;
    // everything else follows from elapsed time since that edge.
    int m_busy  [2];
    int m_start [2];
    int m_pend  [2];
    int m_drop  [2];

    int   rise_a, drops_a;
    logic prev_pulse_a;

    pulse_stretch #(.c_ON_LIMIT(A_ON), .c_GAP_LIMIT(A_GAP), .c_PEND_MAX(A_MAX)) u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_event(ev_a),
        .o_pulse(pulse_a), .o_busy(busy_a), .o_pending(pend_a), .o_drop(drop_a)
    );

    pulse_stretch #(.c_ON_LIMIT(B_ON), .c_GAP_LIMIT(B_GAP), .c_PEND_MAX(B_MAX)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_event(ev_b),
        .o_pulse(pulse_b), .o_busy(busy_b), .o_pending(pend_b), .o_drop(drop_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", tag, t_edge, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_busy[k]  = 0;
            m_start[k] = 0;
            m_pend[k]  = 0;
            m_drop[k]  = 0;
        end
    endtask

    task automatic model_edge(input int k, input int on_l, input int gap_l,
                              input int max_l, input bit ev);
        int rel;
        m_drop[k] = 0;
        if (m_busy[k] == 0) begin
            if (ev) begin
                m_busy[k]  = 1;
                m_start[k] = t_edge;
            end
        end else begin
            rel = t_edge - m_start[k];
            if (rel == on_l + gap_l) begin
                if (m_pend[k] + int'(ev) > 0) begin
                    m_start[k] = t_edge;
                    m_pend[k]  = m_pend[k] + int'(ev) - 1;
                end else begin
                    m_busy[k] = 0;
                end
            end else if (ev) begin
                if (m_pend[k] < max_l) m_pend[k]++;
                else                   m_drop[k] = 1;
            end
        end
    endtask

    function automatic int exp_pulse(input int k, input int on_l);
        return (m_busy[k] != 0 && (t_edge - m_start[k]) < on_l) ? 1 : 0;
    endfunction

    task automatic step(input bit ea, input bit eb, input bit rv);
        @(negedge clk);
        ev_a = ea;
        ev_b = eb;
        rst  = rv;
        @(posedge clk);
        t_edge++;
        if (rv) begin
            model_reset();
        end else begin
            model_edge(0, A_ON, A_GAP, A_MAX, ea);
            model_edge(1, B_ON, B_GAP, B_MAX, eb);
        end
        #1;
        check("a_pulse",   int'(pulse_a), exp_pulse(0, A_ON));
        check("a_busy",    int'(busy_a),  m_busy[0]);
        check("a_pending", int'(pend_a),  m_pend[0]);
        check("a_drop",    int'(drop_a),  m_drop[0]);
        check("b_pulse",   int'(pulse_b), exp_pulse(1, B_ON));
        check("b_busy",    int'(busy_b),  m_busy[1]);
        check("b_pending", int'(pend_b),  m_pend[1]);
        check("b_drop",    int'(drop_b),  m_drop[1]);
        if (pulse_a && !prev_pulse_a) rise_a++;
        if (drop_a) drops_a++;
        prev_pulse_a = pulse_a;
    endtask

    initial begin
        int dens;
        rst  = 1'b1;
        ev_a = 1'b0;
        ev_b = 1'b0;
        prev_pulse_a = 1'b0;
        rise_a  = 0;
        drops_a = 0;
        model_reset();

        // Reset state, with events ignored while reset is held.
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);

        // Single event after a quiet stretch.
        repeat (9) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (10) step(1'b0, 1'b0, 1'b0);

        // One extra event during ON replays after the gap.
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (16) step(1'b0, 1'b0, 1'b0);

        // Burst of events saturates the queue.
        rise_a  = 0;
        drops_a = 0;
        step(1'b1, 1'b0, 1'b0);
        repeat (5) step(1'b1, 1'b0, 1'b0);
        repeat (40) step(1'b0, 1'b0, 1'b0);
        check("burst_pulses", rise_a, 4);
        check("burst_drops", drops_a, 2);
        check("burst_idle", int'(busy_a), 0);

        // Event on the final gap cycle with one pending event.
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("gap_exit_pending", int'(pend_a), 1);
        check("gap_exit_pulse", int'(pulse_a), 1);
        rise_a = 0;
        repeat (20) step(1'b0, 1'b0, 1'b0);
        check("gap_exit_followup", rise_a, 1);

        // Asynchronous reset mid-ON with two events pending.
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("pre_rst_pending", int'(pend_a), 2);
        @(negedge clk);
        ev_a = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_pulse", int'(pulse_a), 0);
        check("async_rst_busy", int'(busy_a), 0);
        check("async_rst_pending", int'(pend_a), 0);
        model_reset();
        step(1'b1, 1'b1, 1'b1);
        rise_a = 0;
        repeat (15) step(1'b0, 1'b0, 1'b0);
        check("post_rst_no_pulse", rise_a, 0);

        // Minimum limits with an event every cycle.
        repeat (20) step(1'b0, 1'b1, 1'b0);
        repeat (6) step(1'b0, 1'b0, 1'b0);

        // Random traffic with varying density and occasional resets.
        for (int blk = 0; blk < 15; blk++) begin
            dens = $urandom_range(1, 8);
            for (int i = 0; i < 200; i++) begin
                step($urandom_range(0, 7) < dens, $urandom_range(0, 7) < dens,
                     $urandom_range(0, 399) == 0);
            end
        end
        repeat (20) step(1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
